// File: rtl/bias_buffer_pp.sv
// Ping-pong bias store: a DMA-fed shadow bank fills while the PE array reads the active bank.
// Define BIAS_BUFFER_RANGE_CHECK_EN to add rd_err and zeroed reads of uncommitted groups.
module bias_buffer_pp #(
    parameter int LANES      = 8,
    parameter int BIAS_W     = 32,
    parameter int BUS_W      = 128,
    parameter int MAX_GROUPS = 128,
    parameter int GRP_W      = $clog2(MAX_GROUPS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld_start,
    input  logic [GRP_W:0]    ld_groups,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [BUS_W-1:0]  wr_data,
    output logic              ld_done,
    input  logic              swap,
    output logic              swap_err,
    output logic              active_bank,
    input  logic              rd_en,
    input  logic [GRP_W-1:0]  rd_group,
    output logic [BIAS_W-1:0] bias_out [LANES],
    output logic              rd_valid
`ifdef BIAS_BUFFER_RANGE_CHECK_EN
    ,
    output logic              rd_err
`endif
);

    localparam int ROW_W = LANES * BIAS_W;
    localparam int BPG   = ROW_W / BUS_W;
    localparam int BC_W  = (BPG > 1) ? $clog2(BPG) : 1;
    localparam logic [BC_W-1:0]  LAST_BEAT = BC_W'(BPG - 1);
    localparam logic [BC_W-1:0]  BEAT_ONE  = BC_W'(1);
    localparam logic [GRP_W:0]   GRP_ONE   = (GRP_W + 1)'(1);

    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

    state_t            state;
    logic [BC_W-1:0]   beat_cnt;
    logic [GRP_W:0]    grp_cnt;
    logic [GRP_W:0]    expected;
    logic [ROW_W-1:0]  pack;
    logic [ROW_W-1:0]  row_next;
    logic [ROW_W-1:0]  rd_row;
    logic              beat_fire;
    logic              last_beat;
    logic              swap_ok;

    logic [ROW_W-1:0]  mem [2][MAX_GROUPS];

`ifdef BIAS_BUFFER_RANGE_CHECK_EN
    logic [GRP_W:0]    active_count;
    logic              out_of_range;
    assign out_of_range = {1'b0, rd_group} >= active_count;
`endif

    // A beat coinciding with ld_start (or reset) is refused, not silently dropped.
    assign wr_ready  = (state == LOAD) && !ld_start && !rst;
    assign beat_fire = wr_valid && wr_ready;
    assign last_beat = (beat_cnt == LAST_BEAT);
    assign ld_done   = (state == DONE);
    assign swap_ok   = swap && ld_done;
    assign rd_row    = mem[active_bank][rd_group];

    always_comb begin
        row_next = pack;
        row_next[beat_cnt*BUS_W +: BUS_W] = wr_data;
    end

    always_ff @(posedge clk) begin
        if (beat_fire && last_beat) begin
            mem[~active_bank][grp_cnt[GRP_W-1:0]] <= row_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            beat_cnt    <= '0;
            grp_cnt     <= '0;
            expected    <= '0;
            pack        <= '0;
            active_bank <= 1'b0;
            swap_err    <= 1'b0;
`ifdef BIAS_BUFFER_RANGE_CHECK_EN
            active_count <= '0;
`endif
        end else begin
            swap_err <= swap && !ld_done;
            if (swap_ok) begin
                active_bank <= ~active_bank;
`ifdef BIAS_BUFFER_RANGE_CHECK_EN
                active_count <= expected;
`endif
            end
            if (ld_start) begin
                beat_cnt <= '0;
                grp_cnt  <= '0;
                expected <= ld_groups;
                state    <= (ld_groups == '0) ? DONE : LOAD;
            end else if (swap_ok) begin
                state <= IDLE;
            end else if (beat_fire) begin
                if (last_beat) begin
                    beat_cnt <= '0;
                    grp_cnt  <= grp_cnt + GRP_ONE;
                    if (grp_cnt + GRP_ONE >= expected) begin
                        state <= DONE;
                    end
                end else begin
                    pack[beat_cnt*BUS_W +: BUS_W] <= wr_data;
                    beat_cnt <= beat_cnt + BEAT_ONE;
                end
            end
        end
    end

    // Reads use the pre-edge active_bank, so a read alongside a swap still sees the old bank.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid <= 1'b0;
            for (int k = 0; k < LANES; k++) begin
                bias_out[k] <= '0;
            end
`ifdef BIAS_BUFFER_RANGE_CHECK_EN
            rd_err <= 1'b0;
`endif
        end else begin
            rd_valid <= rd_en;
`ifdef BIAS_BUFFER_RANGE_CHECK_EN
            rd_err <= rd_en && out_of_range;
            if (rd_en) begin
                for (int k = 0; k < LANES; k++) begin
                    bias_out[k] <= out_of_range ? '0 : rd_row[k*BIAS_W +: BIAS_W];
                end
            end
`else
            if (rd_en) begin
                for (int k = 0; k < LANES; k++) begin
                    bias_out[k] <= rd_row[k*BIAS_W +: BIAS_W];
                end
            end
`endif
        end
    end

endmodule
